// File: rtl/matmul5_sequencer.sv
// matmul5_sequencer
//   Sequences one shared 5-lane int8 MAC unit to compute C = A x B for 5x5
//   matrices. Operands are latched on start. The MAC is fed one A row and one
//   B column per element, in row-major order. Each result is written into C,
//   and a sticky overflow flag is accumulated across the job.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               job request, sampled only while idle
//   mat_a, mat_b        operand matrices, element (r,c) at bits [8(5r+c) +: 8]
//   mac_row_a/col_b     MAC operand lanes; lane k = A(r,k) / B(k,c)
//   mac_en              MAC enable
//   mac_result          MAC result for the current element
//   mac_overflow        MAC overflow for the current element
//   mac_done            MAC completion flag (registered in the MAC)
//   mat_c               result matrix, same layout as mat_a
//   overflow            sticky overflow for the job
//   error               job aborted because mac_done never arrived
//   busy                high whenever the sequencer is not idle
//   done                one-cycle completion pulse (normal or aborted)
module matmul5_sequencer #(
  parameter int DIM     = 5,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DIM*DIM*W-1:0]   mat_a,
  input  logic [DIM*DIM*W-1:0]   mat_b,
  output logic [DIM*W-1:0]       mac_row_a,
  output logic [DIM*W-1:0]       mac_col_b,
  output logic                   mac_en,
  input  logic [W-1:0]           mac_result,
  input  logic                   mac_overflow,
  input  logic                   mac_done,
  output logic [DIM*DIM*W-1:0]   mat_c,
  output logic                   overflow,
  output logic                   error,
  output logic                   busy,
  output logic                   done
);

  localparam int N  = DIM * DIM;
  localparam int IW = $clog2(DIM);
  localparam int EW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_FINISH,
    S_ERR
  } state_t;

  state_t              state_reg;
  logic [N*W-1:0]      a_reg;
  logic [N*W-1:0]      b_reg;
  logic [W-1:0]        c_elem_reg [N];
  logic [IW-1:0]       row_idx_reg;
  logic [IW-1:0]       col_idx_reg;
  logic [TW-1:0]       timer_reg;
  logic                flushed_reg;
  logic                overflow_reg;
  logic                error_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                mac_en_reg;
  logic [DIM*W-1:0]    row_a_reg;
  logic [DIM*W-1:0]    col_b_reg;

  logic [W-1:0]        a_elem [N];
  logic [W-1:0]        b_elem [N];
  logic [IW-1:0]       row_idx_next;
  logic [IW-1:0]       col_idx_next;
  logic [EW-1:0]       row_base_next;
  logic [EW-1:0]       elem_idx;
  logic [DIM*W-1:0]    row_a_next;
  logic [DIM*W-1:0]    col_b_next;
  logic                last_elem;
  logic                timeout_hit;

  // Unpack latched operands into element arrays so rows and columns can be
  // selected by a single element index.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elem
      assign a_elem[gi] = a_reg[gi*W +: W];
      assign b_elem[gi] = b_reg[gi*W +: W];
      assign mat_c[gi*W +: W] = c_elem_reg[gi];
    end
  endgenerate

  // Indices of the element about to be run. LOAD restarts at (0,0); STORE
  // advances column-first and wraps the row after the last column.
  always_comb begin
    row_idx_next = row_idx_reg;
    col_idx_next = col_idx_reg;
    if (state_reg == S_LOAD) begin
      row_idx_next = '0;
      col_idx_next = '0;
    end else if (col_idx_reg == IW'(DIM - 1)) begin
      col_idx_next = '0;
      row_idx_next = (row_idx_reg == IW'(DIM - 1)) ? '0 : row_idx_reg + 1'b1;
    end else begin
      col_idx_next = col_idx_reg + 1'b1;
    end
  end

  assign row_base_next = EW'(row_idx_next) * EW'(DIM);
  assign elem_idx      = EW'(row_idx_reg) * EW'(DIM) + EW'(col_idx_reg);
  assign last_elem     = (row_idx_reg == IW'(DIM - 1)) && (col_idx_reg == IW'(DIM - 1));
  assign timeout_hit   = (timer_reg == TW'(TIMEOUT - 1));

  // Operand lanes for the next element: A row r_next and B column c_next.
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lane
      assign row_a_next[gi*W +: W] = a_elem[row_base_next + EW'(gi)];
      assign col_b_next[gi*W +: W] = b_elem[EW'(gi * DIM) + EW'(col_idx_next)];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      for (int i = 0; i < N; i++) c_elem_reg[i] <= '0;
      row_idx_reg  <= '0;
      col_idx_reg  <= '0;
      timer_reg    <= '0;
      flushed_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      error_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mac_en_reg   <= 1'b0;
      row_a_reg    <= '0;
      col_b_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_reg        <= mat_a;
            b_reg        <= mat_b;
            overflow_reg <= 1'b0;
            error_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            if (flushed_reg) begin
              state_reg <= S_LOAD;
            end else begin
              // The MAC may hold a half-finished count from an abandoned
              // job; clock it with zero operands until it reports done.
              state_reg  <= S_FLUSH;
              mac_en_reg <= 1'b1;
              row_a_reg  <= '0;
              col_b_reg  <= '0;
              timer_reg  <= '0;
            end
          end
        end

        S_FLUSH: begin
          if (mac_done) begin
            flushed_reg <= 1'b1;
            mac_en_reg  <= 1'b0;
            state_reg   <= S_LOAD;
          end else if (timeout_hit) begin
            state_reg   <= S_ERR;
            error_reg   <= 1'b1;
            done_reg    <= 1'b1;
            mac_en_reg  <= 1'b0;
            flushed_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        S_LOAD: begin
          row_idx_reg <= row_idx_next;
          col_idx_reg <= col_idx_next;
          row_a_reg   <= row_a_next;
          col_b_reg   <= col_b_next;
          mac_en_reg  <= 1'b1;
          timer_reg   <= '0;
          state_reg   <= S_RUN;
        end

        S_RUN: begin
          if (mac_done) begin
            c_elem_reg[elem_idx] <= mac_result;
            overflow_reg         <= overflow_reg | mac_overflow;
            mac_en_reg           <= 1'b0;
            state_reg            <= S_STORE;
          end else if (timeout_hit) begin
            state_reg   <= S_ERR;
            error_reg   <= 1'b1;
            done_reg    <= 1'b1;
            mac_en_reg  <= 1'b0;
            flushed_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        S_STORE: begin
          // mac_en is low this cycle, letting the MAC clear its counter.
          row_idx_reg <= row_idx_next;
          col_idx_reg <= col_idx_next;
          if (last_elem) begin
            done_reg  <= 1'b1;
            state_reg <= S_FINISH;
          end else begin
            row_a_reg  <= row_a_next;
            col_b_reg  <= col_b_next;
            mac_en_reg <= 1'b1;
            timer_reg  <= '0;
            state_reg  <= S_RUN;
          end
        end

        S_FINISH: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        S_ERR: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg  <= S_IDLE;
          busy_reg   <= 1'b0;
          mac_en_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mac_row_a = row_a_reg;
  assign mac_col_b = col_b_reg;
  assign mac_en    = mac_en_reg;
  assign overflow  = overflow_reg;
  assign error     = error_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_matmul5_sequencer.sv
// tb_matmul5_sequencer
//   Directed jobs for matmul5_sequencer against a behavioural MAC that raises
//   done on its 6th enabled edge and clears on the edge after done. Expected
//   job results are pushed into a scoreboard queue when each job is issued; a
//   monitor pops and compares whenever done is presented.
module tb_matmul5_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [199:0] mat_a;
  logic [199:0] mat_b;
  logic [39:0]  mac_row_a;
  logic [39:0]  mac_col_b;
  logic         mac_en;
  logic [7:0]   mac_result;
  logic         mac_overflow;
  logic         mac_done;
  logic [199:0] mat_c;
  logic         overflow;
  logic         error;
  logic         busy;
  logic         done;

  matmul5_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mat_a        (mat_a),
    .mat_b        (mat_b),
    .mac_row_a    (mac_row_a),
    .mac_col_b    (mac_col_b),
    .mac_en       (mac_en),
    .mac_result   (mac_result),
    .mac_overflow (mac_overflow),
    .mac_done     (mac_done),
    .mat_c        (mat_c),
    .overflow     (overflow),
    .error        (error),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: no reset, starts mid-sequence. hold suppresses done.
  bit   hold = 1'b0;
  int   mac_cnt = 3;
  logic mac_done_r = 1'b0;
  assign mac_done = mac_done_r;

  always @(posedge clk) begin
    if (mac_done_r) begin
      mac_done_r <= 1'b0;
      mac_cnt    <= 0;
    end else if (mac_en) begin
      mac_cnt <= mac_cnt + 1;
      if (!hold && mac_cnt >= 5) mac_done_r <= 1'b1;
    end
  end

  always_comb begin
    int sum;
    sum = 0;
    for (int k = 0; k < 5; k++)
      sum += int'($signed(mac_row_a[8*k +: 8])) * int'($signed(mac_col_b[8*k +: 8]));
    mac_result   = sum[7:0];
    mac_overflow = (sum > 127) || (sum < -128);
  end

  typedef struct {
    logic [199:0] c;
    logic         ovf;
    logic         err;
    bit           chk_c;
    int           lat;
    int           start_edge;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on done, plus per-cycle protocol checks.
  initial begin : monitor
    logic prev_en, prev_mdone, prev_done;
    exp_t e;
    prev_en = 0; prev_mdone = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 0; prev_mdone = 0; prev_done = 0;
      end else begin
        if (prev_en && prev_mdone) chk("mac_en_low_after_done", 200'(mac_en), 200'(0));
        if (prev_done) chk("done_one_cycle", 200'(done), 200'(0));
        if (done) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no job", cyc);
          end else begin
            e = sb_q.pop_front();
            chk({e.name, "_overflow"}, 200'(overflow), 200'(e.ovf));
            chk({e.name, "_error"}, 200'(error), 200'(e.err));
            chk({e.name, "_busy_at_done"}, 200'(busy), 200'(1));
            if (e.chk_c) chk({e.name, "_mat_c"}, mat_c, e.c);
            if (e.lat >= 0) chk({e.name, "_latency"}, 200'(cyc - e.start_edge), 200'(e.lat));
            $display("job %s: done at cycle %0d overflow=%0b error=%0b mat_c=%0h",
                     e.name, cyc, overflow, error, mat_c);
          end
        end
        prev_en = mac_en; prev_mdone = mac_done; prev_done = done;
      end
    end
  end

  function automatic logic [199:0] first_ops(input logic [199:0] a, input logic [199:0] b);
    logic [39:0] col;
    for (int k = 0; k < 5; k++) col[8*k +: 8] = b[8*(5*k) +: 8];
    return 200'({a[39:0], col});
  endfunction

  task automatic run_job(input string name, input logic [199:0] a, input logic [199:0] b,
                         input logic [199:0] exp_c, input bit exp_ovf, input bit exp_err,
                         input bit chk_c, input bit exp_flush, input int lat, input bit poke);
    exp_t e;
    int drops;
    bit seen;
    @(negedge clk);
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    e.c = exp_c; e.ovf = exp_ovf; e.err = exp_err; e.chk_c = chk_c;
    e.lat = lat; e.start_edge = cyc + 1; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    // First enabled cycle: zero operands when flushing, else row 0 / column 0.
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mac_en) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_mac_en: got mac_en=0 for 20 cycles expected 1", name);
    end else begin
      chk({name, "_first_ops"}, 200'({mac_row_a, mac_col_b}),
          exp_flush ? 200'(0) : first_ops(a, b));
    end
    if (poke) begin
      repeat (30) @(negedge clk);
      mat_a = {25{8'h07}};
      mat_b = {25{8'h07}};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    drops = 0;
    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      if (sb_q.size() != 0 && !busy) drops++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_completion: got no done in 3000 cycles expected done", name);
      sb_q.delete();
    end
    chk({name, "_busy_held"}, 200'(drops), 200'(0));
    @(negedge clk);
    chk({name, "_idle_after"}, 200'(busy), 200'(0));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [199:0] a, b, ec;
    rst_n = 1'b0;
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_mat_c", mat_c, 200'(0));
    chk("reset_flags", 200'({overflow, error, busy, done, mac_en}), 200'(0));
    chk("reset_ops", 200'({mac_row_a, mac_col_b}), 200'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Job 1: A = I, B(r,c) = 5r+c -> C = B; first job after reset flushes.
    a = '0; b = '0;
    for (int r = 0; r < 5; r++) a[8*(5*r + r) +: 8] = 8'd1;
    for (int i = 0; i < 25; i++) b[8*i +: 8] = 8'(i);
    run_job("ident", a, b, b, 0, 0, 1, 1, -1, 0);

    // Job 2: all 2 x all 3 -> 30 everywhere, done 201 edges after start.
    // A start pulse mid-job must be ignored.
    run_job("twos_threes", {25{8'd2}}, {25{8'd3}}, {25{8'd30}}, 0, 0, 1, 0, 201, 1);

    // Job 3: A row 0 = -1, B column 0 = 7 -> C(0,0) = -35 = 0xDD, rest 0.
    a = '0; b = '0; ec = '0;
    for (int k = 0; k < 5; k++) begin
      a[8*k +: 8] = 8'hFF;
      b[8*(5*k) +: 8] = 8'd7;
    end
    ec[7:0] = 8'hDD;
    run_job("signed", a, b, ec, 0, 0, 1, 0, 201, 0);

    // Job 4: A row 2 = 100, B column 3 = 100 -> C(2,3) = 50000 mod 256 = 0x50.
    a = '0; b = '0; ec = '0;
    for (int k = 0; k < 5; k++) begin
      a[8*(10 + k) +: 8] = 8'd100;
      b[8*(5*k + 3) +: 8] = 8'd100;
    end
    ec[8*13 +: 8] = 8'h50;
    run_job("overflow", a, b, ec, 1, 0, 1, 0, 201, 0);
    repeat (5) @(negedge clk);
    chk("overflow_held", 200'(overflow), 200'(1));

    // Job 5: clean job clears sticky overflow.
    a = '0; b = '0;
    for (int r = 0; r < 5; r++) a[8*(5*r + r) +: 8] = 8'd1;
    for (int i = 0; i < 25; i++) b[8*i +: 8] = 8'(i);
    run_job("clean", a, b, b, 0, 0, 1, 0, 201, 0);

    // Job 6: MAC never finishes -> ERR after 64 RUN cycles, done at edge 65.
    hold = 1'b1;
    run_job("timeout", a, b, '0, 0, 1, 0, 0, 65, 0);
    hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("error_held", 200'(error), 200'(1));
    chk("mac_en_after_err", 200'(mac_en), 200'(0));

    // Job 7: after ERR the next job flushes first and clears error.
    run_job("after_timeout", {25{8'd2}}, {25{8'd3}}, {25{8'd30}}, 0, 0, 1, 1, -1, 0);

    // Mid-job reset around element 12 (RUN of element 12 begins edge 97).
    @(negedge clk);
    mat_a = {25{8'd1}};
    mat_b = {25{8'd1}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("busy_midjob", 200'(busy), 200'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_mat_c", mat_c, 200'(0));
    chk("async_reset_flags", 200'({overflow, error, busy, done, mac_en}), 200'(0));
    chk("async_reset_ops", 200'({mac_row_a, mac_col_b}), 200'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Job 8: A(r,c) = r-c, B = I -> C = A; must flush after the reset.
    a = '0; b = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) a[8*(5*r + c) +: 8] = 8'(r - c);
    for (int r = 0; r < 5; r++) b[8*(5*r + r) +: 8] = 8'd1;
    run_job("after_reset", a, b, a, 0, 0, 1, 1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul5_sequencer.md
Name: matmul5_sequencer

Overview:
- Sequences one shared 5-element int8 two's-complement MAC unit to compute C = A×B for 5×5 matrices. The MAC consumes one A row and one B column and returns one C element.
- Latches both operand matrices on start and feeds the MAC 25 times in row-major order. Captures each result into the C register and tracks sticky overflow.
- Sits between the HPS-facing register interface and the MAC datapath.

Parameters:
- DIM, 5, matrix dimension. Fixed at 5; the MAC lane count is 5.
- W, 8, element width in bits.
- TIMEOUT, 64, maximum cycles allowed in RUN/FLUSH waiting for mac_done.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request. Sampled only in IDLE.
- mat_a  in  200  A matrix; element (r,c) at bits [8(5r+c)+7 : 8(5r+c)].
- mat_b  in  200  B matrix; same layout as mat_a.
- mac_row_a  out  40  to MAC inA; lane k = A(r,k).
- mac_col_b  out  40  to MAC inB; lane k = B(k,c).
- mac_en  out  1  MAC enable.
- mac_result  in  8  MAC accumulated result.
- mac_overflow  in  1  MAC overflow, combinational on its inputs.
- mac_done  in  1  MAC completion flag, registered. The MAC self-clears on the edge after mac_done is seen.
- mat_c  out  200  result matrix; same layout as mat_a.
- overflow  out  1  sticky: any element overflowed during the job.
- error  out  1  job aborted by timeout.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE; mat_c=0, overflow=0, error=0, busy=0, done=0, mac_en=0, mac_row_a=0, mac_col_b=0; internal A/B latches, row/col indices and timer = 0; flushed=0.
- The MAC has no external reset. A job the sequencer abandons leaves the MAC counter mid-sequence. The flushed flag handles this.

State machine:
- IDLE:
  - On start=1, latch mat_a/mat_b internally and clear overflow/error.
  - mat_c holds its previous value until overwritten.
  - Next state: FLUSH if flushed=0, else LOAD.
- FLUSH:
  - mac_en=1, operands driven 0.
  - On mac_done=1, discard the result, set flushed=1, go to LOAD.
- LOAD: set r=0, c=0 (1 cycle). Go to RUN.
- RUN:
  - mac_en=1; drive mac_row_a = A row r and mac_col_b = B column c from the latches.
  - On mac_done=1: write mac_result into C(r,c), OR mac_overflow into overflow, go to STORE.
- STORE:
  - mac_en=0 for one cycle; the MAC self-clears on this edge.
  - Advance c; on wrap from 4 to 0, advance r.
  - Next state: FINISH after element (4,4), else RUN.
- FINISH: done=1 for one cycle, then IDLE.
- ERR:
  - Entered from RUN or FLUSH when the timer reaches TIMEOUT without mac_done.
  - Sets error=1, done=1 (one cycle), mac_en=0, flushed=0, then IDLE.
  - mat_c is partially written and undefined.

Rules:
- The timer clears on entry to RUN/FLUSH and increments each cycle spent there.
- start while busy=1 is ignored; the job is not queued.
- Operand lanes update only on the LOAD/STORE→RUN transition, so they are stable for the whole RUN.
- Timing, with a MAC that asserts done on its 6th enabled edge:
  - RUN lasts 7 cycles; each element takes 8 cycles.
  - With flushed=1, done rises 201 edges after the edge that samples start.
- rst_n asserted mid-job: outputs take their reset values immediately and flushed=0. The next job flushes first.
- done and error are never asserted outside FINISH/ERR.

Test Plan:
- Post-reset job with A=I, B(r,c)=5r+c → one FLUSH pass precedes LOAD; mat_c equals mat_b; overflow=0; done one cycle; busy high throughout.
- Second job, A all 2, B all 3 (flushed=1) → every C element=30; done exactly 201 edges after start is sampled; mac_en low in each STORE cycle.
- Signed values: A(0,*)=-1, B(*,0)=7 → C(0,0)=-35 (0xDD); other elements as computed; overflow=0.
- Overflow: A(2,*)=100, B(*,3)=100 with model overflow asserted → overflow=1 at done and held until the next start; the next clean job clears it.
- Timeout: hold mac_done=0 → after 64 RUN cycles enter ERR; error=1, done pulse, mac_en=0; the next job performs FLUSH.
- Mid-job rst_n low at element 12 → all outputs reset asynchronously; start during busy ignored; the subsequent job flushes and completes correctly.
